// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use stall hold, flush bubble,
// write-back operand refresh and stall monitoring.
module id_ex_reg #(
    parameter int unsigned STALL_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rd_addr,
    input  logic [3:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_reg_write,
    input  logic        ex_stop,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rs1_addr,
    output logic [4:0]  ex_rs2_addr,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd_addr,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        hold_upstream,
    output logic        bubble_out,
    output logic        stall_err,
    output logic [7:0]  stall_cnt
);
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd_addr;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } ex_t;

    ex_t         ex_d, ex_q;
    logic        bub_d, bub_q, err_d, err_q;
    logic [7:0]  cnt_d, cnt_q;
    logic [31:0] run_d, run_q;
    logic        stall, hit1, hit2;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;

    assign stall = ex_stop & ~flush;
    // Refresh targets the held operands while stalling, the incoming ones while loading
    assign a1 = stall ? ex_q.rs1_addr : id_rs1_addr;
    assign a2 = stall ? ex_q.rs2_addr : id_rs2_addr;
    assign d1 = stall ? ex_q.rs1_data : id_rs1_data;
    assign d2 = stall ? ex_q.rs2_data : id_rs2_data;
    assign hit1 = wb_we & (|wb_addr) & (wb_addr == a1);
    assign hit2 = wb_we & (|wb_addr) & (wb_addr == a2);

    always_comb begin
        ex_d  = ex_q;
        bub_d = 1'b0;
        run_d = '0;
        cnt_d = cnt_q;
        err_d = err_q;
        if (flush) begin
            ex_d = '0;
        end else if (ex_stop) begin
            ex_d.rs1_data = hit1 ? wb_data : d1;
            ex_d.rs2_data = hit2 ? wb_data : d2;
            bub_d = 1'b1;
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            run_d = (run_q >= STALL_MAX) ? run_q : run_q + 32'd1;
            err_d = err_q | (run_d >= STALL_MAX);
        end else begin
            ex_d = '{valid: id_valid, pc: id_pc, rs1_addr: id_rs1_addr, rs2_addr: id_rs2_addr,
                     rs1_data: hit1 ? wb_data : d1, rs2_data: hit2 ? wb_data : d2,
                     imm: id_imm, rd_addr: id_rd_addr, alu_op: id_alu_op, alu_src: id_alu_src,
                     mem_read: id_mem_read & id_valid, mem_write: id_mem_write & id_valid,
                     reg_write: id_reg_write & id_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            bub_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
            run_q <= '0;
        end else begin
            ex_q  <= ex_d;
            bub_q <= bub_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_addr   = ex_q.rs1_addr;
    assign ex_rs2_addr   = ex_q.rs2_addr;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign hold_upstream = ex_stop & ~flush & ~rst;
    assign bubble_out    = bub_q;
    assign stall_err     = err_q;
    assign stall_cnt     = cnt_q;
endmodule
